// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI response/burst codes, FSM state types and beat helpers
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

    // Only FIXED and INCR are serviced; WRAP and the reserved code poison every beat.
    function automatic logic burst_supported(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

    function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                   input logic [1:0]  burst,
                                                   input logic [31:0] step);
        return (burst == BURST_INCR) ? addr + step : addr;
    endfunction

endpackage

// File: rtl/sdp_ram_be.sv
// rtl/sdp_ram_be.sv - simple dual-port RAM, byte-enable write port, registered read port
module sdp_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write and read share one edge, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_slave_bram.sv
// rtl/axi_slave_bram.sv - AXI4 slave endpoint backed by a byte-addressable on-chip RAM
module axi_slave_bram
    import axi_pkg::*;
#(
    parameter int ID_WIDTH       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ID_WIDTH-1:0]     WR_ADDR_ID,
    input  logic [31:0]             WR_ADDR,
    input  logic [7:0]              WR_ADDR_LEN,
    input  logic [1:0]              WR_ADDR_BURST,
    input  logic                    WR_ADDR_VALID,
    output logic                    WR_ADDR_READY,
    input  logic [DATA_WIDTH-1:0]   WR_DATA,
    input  logic [DATA_WIDTH/8-1:0] WR_STRB,
    input  logic                    WR_DATA_LAST,
    input  logic                    WR_DATA_VALID,
    output logic                    WR_DATA_READY,
    output logic [ID_WIDTH-1:0]     WR_BACK_ID,
    output logic [1:0]              WR_BACK_RESP,
    output logic                    WR_BACK_VALID,
    input  logic                    WR_BACK_READY,
    input  logic [ID_WIDTH-1:0]     RD_ADDR_ID,
    input  logic [31:0]             RD_ADDR,
    input  logic [7:0]              RD_ADDR_LEN,
    input  logic [1:0]              RD_ADDR_BURST,
    input  logic                    RD_ADDR_VALID,
    output logic                    RD_ADDR_READY,
    output logic [ID_WIDTH-1:0]     RD_BACK_ID,
    output logic [DATA_WIDTH-1:0]   RD_DATA,
    output logic [1:0]              RD_DATA_RESP,
    output logic                    RD_DATA_LAST,
    output logic                    RD_DATA_VALID,
    input  logic                    RD_DATA_READY
);

    localparam int          BYTES      = DATA_WIDTH / 8;
    localparam int          LSB        = $clog2(BYTES);
    localparam logic [32:0] ADDR_LIMIT = 33'd1 << (MEM_DEPTH_LOG2 + LSB);
    localparam logic [31:0] STEP       = 32'(BYTES);

    function automatic logic beat_error(input logic [31:0] addr, input logic [1:0] burst);
        return !burst_supported(burst) || ({1'b0, addr} >= ADDR_LIMIT);
    endfunction

    // Holds both address READYs low until the first edge after reset release.
    logic live;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    wr_state_t             w_state, w_state_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [31:0]           w_addr;
    logic [1:0]            w_burst;
    logic                  w_err;
    logic                  aw_hs, w_hs, w_beat_err;

    always_comb begin
        w_state_next  = w_state;
        WR_ADDR_READY = 1'b0;
        WR_DATA_READY = 1'b0;
        WR_BACK_VALID = 1'b0;
        WR_BACK_ID    = '0;
        WR_BACK_RESP  = RESP_OKAY;
        case (w_state)
            W_IDLE: begin
                WR_ADDR_READY = live;
                if (WR_ADDR_VALID && live) begin
                    w_state_next = W_DATA;
                end
            end
            W_DATA: begin
                WR_DATA_READY = 1'b1;
                if (WR_DATA_VALID && WR_DATA_LAST) begin
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                WR_BACK_VALID = 1'b1;
                WR_BACK_ID    = w_id;
                WR_BACK_RESP  = w_err ? RESP_SLVERR : RESP_OKAY;
                if (WR_BACK_READY) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign aw_hs      = WR_ADDR_VALID && WR_ADDR_READY;
    assign w_hs       = WR_DATA_VALID && WR_DATA_READY;
    assign w_beat_err = beat_error(w_addr, w_burst);

    // WLAST alone closes the burst, so the latched length has no consumer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_burst <= BURST_INCR;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_state_next;
            if (aw_hs) begin
                w_id    <= WR_ADDR_ID;
                w_addr  <= WR_ADDR;
                w_burst <= WR_ADDR_BURST;
                w_err   <= 1'b0;
            end else if (w_hs) begin
                w_addr <= next_beat_addr(w_addr, w_burst, STEP);
                if (w_beat_err) begin
                    w_err <= 1'b1;
                end
            end
        end
    end

    rd_state_t             r_state, r_state_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [31:0]           r_addr;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic                  r_err;
    logic                  r_last, r_fetch, ar_hs, r_hs;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign r_last = (r_cnt == 8'd0);

    always_comb begin
        r_state_next  = r_state;
        r_fetch       = 1'b0;
        RD_ADDR_READY = 1'b0;
        RD_DATA_VALID = 1'b0;
        RD_BACK_ID    = '0;
        RD_DATA       = '0;
        RD_DATA_RESP  = RESP_OKAY;
        RD_DATA_LAST  = 1'b0;
        case (r_state)
            R_IDLE: begin
                RD_ADDR_READY = live;
                if (RD_ADDR_VALID && live) begin
                    r_state_next = R_FETCH;
                end
            end
            R_FETCH: begin
                r_fetch      = 1'b1;
                r_state_next = R_DATA;
            end
            R_DATA: begin
                RD_DATA_VALID = 1'b1;
                RD_BACK_ID    = r_id;
                RD_DATA       = r_err ? '0 : ram_rd_data;
                RD_DATA_RESP  = r_err ? RESP_SLVERR : RESP_OKAY;
                RD_DATA_LAST  = r_last;
                if (RD_DATA_READY) begin
                    r_state_next = r_last ? R_IDLE : R_FETCH;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    assign ar_hs = RD_ADDR_VALID && RD_ADDR_READY;
    assign r_hs  = RD_DATA_VALID && RD_DATA_READY;

    // The beat's error status is captured alongside the RAM read so R stays stable under backpressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_burst <= BURST_INCR;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= r_state_next;
            if (ar_hs) begin
                r_id    <= RD_ADDR_ID;
                r_addr  <= RD_ADDR;
                r_burst <= RD_ADDR_BURST;
                r_cnt   <= RD_ADDR_LEN;
            end
            if (r_fetch) begin
                r_err <= beat_error(r_addr, r_burst);
            end
            if (r_hs && !r_last) begin
                r_cnt  <= r_cnt - 8'd1;
                r_addr <= next_beat_addr(r_addr, r_burst, STEP);
            end
        end
    end

    sdp_ram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_hs && !w_beat_err),
        .wr_addr (w_addr[LSB +: MEM_DEPTH_LOG2]),
        .wr_data (WR_DATA),
        .wr_strb (WR_STRB),
        .rd_en   (r_fetch),
        .rd_addr (r_addr[LSB +: MEM_DEPTH_LOG2]),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_axi_slave_bram.sv
// tb/tb_axi_slave_bram.sv - self-checking bench for axi_slave_bram
module tb_axi_slave_bram;
    import axi_pkg::*;

    localparam int IDW = 4;
    localparam int DW  = 32;
    localparam int DL2 = 10;
    localparam logic [31:0] MEM_BYTES = 32'd1 << (DL2 + 2);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [IDW-1:0] WR_ADDR_ID, WR_BACK_ID, RD_ADDR_ID, RD_BACK_ID;
    logic [31:0]    WR_ADDR, RD_ADDR;
    logic [7:0]     WR_ADDR_LEN, RD_ADDR_LEN;
    logic [1:0]     WR_ADDR_BURST, RD_ADDR_BURST, WR_BACK_RESP, RD_DATA_RESP;
    logic           WR_ADDR_VALID, WR_ADDR_READY, WR_DATA_LAST, WR_DATA_VALID, WR_DATA_READY;
    logic           WR_BACK_VALID, WR_BACK_READY, RD_ADDR_VALID, RD_ADDR_READY;
    logic           RD_DATA_LAST, RD_DATA_VALID, RD_DATA_READY;
    logic [DW-1:0]  WR_DATA, RD_DATA;
    logic [DW/8-1:0] WR_STRB;

    axi_slave_bram #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rstn(rstn),
        .WR_ADDR_ID(WR_ADDR_ID), .WR_ADDR(WR_ADDR), .WR_ADDR_LEN(WR_ADDR_LEN),
        .WR_ADDR_BURST(WR_ADDR_BURST), .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
        .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_DATA_LAST(WR_DATA_LAST),
        .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
        .WR_BACK_ID(WR_BACK_ID), .WR_BACK_RESP(WR_BACK_RESP), .WR_BACK_VALID(WR_BACK_VALID),
        .WR_BACK_READY(WR_BACK_READY),
        .RD_ADDR_ID(RD_ADDR_ID), .RD_ADDR(RD_ADDR), .RD_ADDR_LEN(RD_ADDR_LEN),
        .RD_ADDR_BURST(RD_ADDR_BURST), .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
        .RD_BACK_ID(RD_BACK_ID), .RD_DATA(RD_DATA), .RD_DATA_RESP(RD_DATA_RESP),
        .RD_DATA_LAST(RD_DATA_LAST), .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_READY(RD_DATA_READY)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem_m [0:1023];
    logic [31:0] wq_data[$];
    logic [3:0]  wq_strb[$];
    logic [31:0] exp_data[$];
    logic [1:0]  exp_resp[$];
    logic [31:0] got_data[$];
    logic [1:0]  got_resp[$];
    logic        got_last[$];
    logic [3:0]  got_id[$];

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          step;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit wr, logic [3:0] id, logic [31:0] addr, logic [7:0] len,
                                logic [1:0] burst, logic [3:0] strb, logic [31:0] data,
                                logic [1:0] resp, bit step);
        return '{wr, id, addr, len, burst, strb, data, resp, step};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return WR_ADDR_READY;
            1: return WR_DATA_READY;
            2: return WR_BACK_VALID;
            3: return RD_ADDR_READY;
            default: return RD_DATA_VALID;
        endcase
    endfunction

    task automatic wait_for(input int w, input string name);
        for (int k = 0; k < 64 && !sig(w); k++) @(negedge clk);
        if (!sig(w)) begin
            n_err++;
            $display("FAIL timeout %s: got 0 after 64 cycles, required 1", name);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $fatal(1);
        end
    endtask

    function automatic logic beat_bad(input logic [31:0] a, input logic [1:0] burst);
        return (burst != BURST_FIXED && burst != BURST_INCR) || (a >= MEM_BYTES);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, output logic [1:0] resp);
        logic [31:0] a = addr;
        resp = RESP_OKAY;
        for (int i = 0; i <= int'(len); i++) begin
            if (beat_bad(a, burst)) resp = RESP_SLVERR;
            else for (int b = 0; b < 4; b++)
                if (wq_strb[i][b]) mem_m[a >> 2][b*8 +: 8] = wq_data[i][b*8 +: 8];
            if (burst == BURST_INCR) a = a + 4;
        end
    endtask

    task automatic model_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] a = addr;
        exp_data.delete(); exp_resp.delete();
        for (int i = 0; i <= int'(len); i++) begin
            exp_data.push_back(beat_bad(a, burst) ? 32'h0 : mem_m[a >> 2]);
            exp_resp.push_back(beat_bad(a, burst) ? RESP_SLVERR : RESP_OKAY);
            if (burst == BURST_INCR) a = a + 4;
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int bdelay,
                             output logic [1:0] bresp, output logic [3:0] bid);
        int c0;
        @(negedge clk);
        WR_ADDR_ID = id; WR_ADDR = addr; WR_ADDR_LEN = len; WR_ADDR_BURST = burst; WR_ADDR_VALID = 1'b1;
        wait_for(0, "awready");
        c0 = cyc;
        @(posedge clk); #1 WR_ADDR_VALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WR_DATA = wq_data[i]; WR_STRB = wq_strb[i]; WR_DATA_LAST = (i == int'(len)); WR_DATA_VALID = 1'b1;
            @(negedge clk);
            wait_for(1, "wready");
            @(posedge clk); #1;
        end
        WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0;
        @(negedge clk);
        wait_for(2, "bvalid");
        check($sformatf("write turnaround @%08h", addr), 64'(cyc - c0), 64'(int'(len) + 2));
        for (int k = 0; k < bdelay; k++) begin
            check("bvalid held", WR_BACK_VALID, 1'b1);
            check("bid held", WR_BACK_ID, id);
            check("awready low while B pending", WR_ADDR_READY, 1'b0);
            @(negedge clk);
        end
        WR_BACK_READY = 1'b1;
        bresp = WR_BACK_RESP; bid = WR_BACK_ID;
        @(posedge clk); #1 WR_BACK_READY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit toggle);
        int c0, cp;
        logic [38:0] snap;
        got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete();
        @(negedge clk);
        RD_ADDR_ID = id; RD_ADDR = addr; RD_ADDR_LEN = len; RD_ADDR_BURST = burst; RD_ADDR_VALID = 1'b1;
        wait_for(3, "arready");
        c0 = cyc; cp = c0;
        @(posedge clk); #1 RD_ADDR_VALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            RD_DATA_READY = !toggle;
            @(negedge clk);
            wait_for(4, "rvalid");
            if (!toggle) check($sformatf("rvalid spacing beat %0d", i), 64'(cyc - cp), 64'd2);
            else begin
                snap = {RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST};
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check("R stable while not ready",
                          {RD_DATA_VALID, RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST}, {1'b1, snap});
                end
                RD_DATA_READY = 1'b1;
            end
            cp = cyc;
            got_data.push_back(RD_DATA); got_resp.push_back(RD_DATA_RESP);
            got_last.push_back(RD_DATA_LAST); got_id.push_back(RD_BACK_ID);
            @(posedge clk); #1 RD_DATA_READY = 1'b0;
        end
    endtask

    task automatic compare_read(input string tag, input logic [7:0] len, input logic [3:0] id);
        check({tag, " beats"}, 64'(got_data.size()), 64'(int'(len) + 1));
        for (int i = 0; i <= int'(len) && i < got_data.size(); i++) begin
            check($sformatf("%s rdata[%0d]", tag, i), got_data[i], exp_data[i]);
            check($sformatf("%s rresp[%0d]", tag, i), got_resp[i], exp_resp[i]);
            check($sformatf("%s rlast[%0d]", tag, i), got_last[i], i == int'(len));
            check($sformatf("%s rid[%0d]", tag, i), got_id[i], id);
        end
    endtask

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        logic [1:0]  bresp, eresp, burst;
        logic [3:0]  bid, id;
        logic [31:0] addr, oldw;
        logic [7:0]  len;
        int          r;
        vec_t        v;

        WR_ADDR_ID = '0; WR_ADDR = '0; WR_ADDR_LEN = '0; WR_ADDR_BURST = '0; WR_ADDR_VALID = 1'b0;
        WR_DATA = '0; WR_STRB = '0; WR_DATA_LAST = 1'b0; WR_DATA_VALID = 1'b0; WR_BACK_READY = 1'b0;
        RD_ADDR_ID = '0; RD_ADDR = '0; RD_ADDR_LEN = '0; RD_ADDR_BURST = '0; RD_ADDR_VALID = 1'b0;
        RD_DATA_READY = 1'b0;

        repeat (3) @(negedge clk);
        check("reset ready/valid/last",
              {WR_ADDR_READY, WR_DATA_READY, WR_BACK_VALID, RD_ADDR_READY, RD_DATA_VALID, RD_DATA_LAST}, 0);
        check("reset id/resp", {WR_BACK_ID, WR_BACK_RESP, RD_BACK_ID, RD_DATA_RESP}, 0);
        check("reset rdata", RD_DATA, 0);
        #2 rstn = 1'b1;
        @(negedge clk);
        check("awready after reset", WR_ADDR_READY, 1'b1);
        check("arready after reset", RD_ADDR_READY, 1'b1);

        // Give the whole RAM known contents so every later read has a defined expectation.
        for (int blk = 0; blk < 4; blk++) begin
            wq_data.delete(); wq_strb.delete();
            for (int i = 0; i < 256; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
            model_write(32'(blk * 1024), 8'd255, BURST_INCR, eresp);
            axi_write(4'(blk), 32'(blk * 1024), 8'd255, BURST_INCR, 0, bresp, bid);
            check($sformatf("fill bresp %0d", blk), bresp, RESP_OKAY);
        end

        tbl.push_back(mk(1, 4'h5, 32'h010,  8'd0, BURST_INCR,  4'hF, 32'hDEADBEEF, RESP_OKAY,   0));
        tbl.push_back(mk(0, 4'h5, 32'h010,  8'd0, BURST_INCR,  4'hF, 32'hDEADBEEF, RESP_OKAY,   0));
        tbl.push_back(mk(1, 4'h3, 32'h100,  8'd3, BURST_INCR,  4'hF, 32'h1,        RESP_OKAY,   0));
        tbl.push_back(mk(0, 4'h3, 32'h100,  8'd3, BURST_INCR,  4'hF, 32'h1,        RESP_OKAY,   1));
        tbl.push_back(mk(1, 4'hA, 32'h020,  8'd0, BURST_INCR,  4'hF, 32'hFFFFFFFF, RESP_OKAY,   0));
        tbl.push_back(mk(1, 4'hA, 32'h020,  8'd0, BURST_INCR,  4'h3, 32'h0000AAAA, RESP_OKAY,   0));
        tbl.push_back(mk(0, 4'hA, 32'h020,  8'd0, BURST_INCR,  4'hF, 32'hFFFFAAAA, RESP_OKAY,   0));
        tbl.push_back(mk(1, 4'h6, 32'h000,  8'd0, BURST_INCR,  4'hF, 32'h12345678, RESP_OKAY,   0));
        tbl.push_back(mk(1, 4'h6, 32'h1000, 8'd0, BURST_INCR,  4'hF, 32'hCAFEF00D, RESP_SLVERR, 0));
        tbl.push_back(mk(0, 4'h6, 32'h000,  8'd0, BURST_INCR,  4'hF, 32'h12345678, RESP_OKAY,   0));
        tbl.push_back(mk(0, 4'h7, 32'h1000, 8'd1, BURST_INCR,  4'hF, 32'h0,        RESP_SLVERR, 0));
        tbl.push_back(mk(1, 4'h8, 32'hFFC,  8'd1, BURST_INCR,  4'hF, 32'h55AA0000, RESP_SLVERR, 0));
        tbl.push_back(mk(0, 4'h8, 32'hFFC,  8'd0, BURST_INCR,  4'hF, 32'h55AA0000, RESP_OKAY,   0));
        tbl.push_back(mk(0, 4'h8, 32'h000,  8'd0, BURST_INCR,  4'hF, 32'h12345678, RESP_OKAY,   0));
        tbl.push_back(mk(1, 4'h9, 32'h040,  8'd2, BURST_FIXED, 4'hF, 32'hA0,       RESP_OKAY,   0));
        tbl.push_back(mk(0, 4'h9, 32'h040,  8'd0, BURST_INCR,  4'hF, 32'hA2,       RESP_OKAY,   0));
        tbl.push_back(mk(0, 4'h2, 32'h040,  8'd2, BURST_FIXED, 4'hF, 32'hA2,       RESP_OKAY,   0));
        tbl.push_back(mk(1, 4'hB, 32'h050,  8'd1, BURST_WRAP,  4'hF, 32'h77,       RESP_SLVERR, 0));
        tbl.push_back(mk(0, 4'hB, 32'h050,  8'd1, BURST_WRAP,  4'hF, 32'h0,        RESP_SLVERR, 0));
        tbl.push_back(mk(1, 4'hF, 32'h060,  8'd0, 2'b11,       4'hF, 32'h99,       RESP_SLVERR, 0));

        for (int n = 0; n < tbl.size(); n++) begin
            v = tbl[n];
            if (v.wr) begin
                wq_data.delete(); wq_strb.delete();
                for (int i = 0; i <= int'(v.len); i++) begin
                    wq_data.push_back(v.data + 32'(i)); wq_strb.push_back(v.strb);
                end
                model_write(v.addr, v.len, v.burst, eresp);
                axi_write(v.id, v.addr, v.len, v.burst, 0, bresp, bid);
                check($sformatf("vec%0d bresp", n), bresp, v.resp);
                check($sformatf("vec%0d bid", n), bid, v.id);
            end else begin
                exp_data.delete(); exp_resp.delete();
                for (int i = 0; i <= int'(v.len); i++) begin
                    exp_data.push_back(v.data + (v.step ? 32'(i) : 32'd0)); exp_resp.push_back(v.resp);
                end
                axi_read(v.id, v.addr, v.len, v.burst, 0);
                compare_read($sformatf("vec%0d", n), v.len, v.id);
            end
        end

        // B channel backpressure.
        wq_data = '{32'h13572468}; wq_strb = '{4'hF};
        model_write(32'h300, 8'd0, BURST_INCR, eresp);
        axi_write(4'hE, 32'h300, 8'd0, BURST_INCR, 5, bresp, bid);
        check("bp bresp", bresp, RESP_OKAY);
        check("bp bid", bid, 4'hE);

        // R channel backpressure on the earlier 1,2,3,4 burst.
        exp_data = '{32'h1, 32'h2, 32'h3, 32'h4};
        exp_resp = '{RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY};
        axi_read(4'h3, 32'h100, 8'd3, BURST_INCR, 1);
        compare_read("rready toggle", 8'd3, 4'h3);

        // Same-word write and read launched together: the read must see the old word.
        oldw = mem_m[32'h180 >> 2];
        wq_data = '{32'hC0117150}; wq_strb = '{4'hF};
        fork
            axi_write(4'h1, 32'h180, 8'd0, BURST_INCR, 0, bresp, bid);
            axi_read(4'h2, 32'h180, 8'd0, BURST_INCR, 0);
        join
        check("collision read old", got_data[0], oldw);
        check("collision bresp", bresp, RESP_OKAY);
        model_write(32'h180, 8'd0, BURST_INCR, eresp);
        model_read(32'h180, 8'd0, BURST_INCR);
        axi_read(4'h2, 32'h180, 8'd0, BURST_INCR, 0);
        compare_read("after collision", 8'd0, 4'h2);

        // Reset in the middle of a read burst.
        @(negedge clk);
        RD_ADDR_ID = 4'h9; RD_ADDR = 32'h200; RD_ADDR_LEN = 8'd7; RD_ADDR_BURST = BURST_INCR; RD_ADDR_VALID = 1'b1;
        wait_for(3, "arready");
        @(posedge clk); #1 RD_ADDR_VALID = 1'b0; RD_DATA_READY = 1'b1;
        @(negedge clk); wait_for(4, "rvalid");
        @(posedge clk); #1;
        @(negedge clk); wait_for(4, "rvalid");
        #2 rstn = 1'b0;
        #1;
        check("rvalid in reset", RD_DATA_VALID, 1'b0);
        check("arready in reset", RD_ADDR_READY, 1'b0);
        check("R outputs in reset", {RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST}, 0);
        RD_DATA_READY = 1'b0;
        repeat (2) @(negedge clk);
        check("awready held in reset", WR_ADDR_READY, 1'b0);
        #2 rstn = 1'b1;
        @(negedge clk);
        check("arready after release", RD_ADDR_READY, 1'b1);
        check("rvalid after release", RD_DATA_VALID, 1'b0);
        model_read(32'h200, 8'd3, BURST_INCR);
        axi_read(4'h9, 32'h200, 8'd3, BURST_INCR, 0);
        compare_read("post-reset read", 8'd3, 4'h9);

        for (int t = 0; t < 40; t++) begin
            id = 4'($urandom);
            addr = 32'($urandom_range(0, 32'h410)) << 2;
            len = 8'($urandom_range(0, 7));
            r = int'($urandom_range(0, 9));
            burst = (r < 5) ? BURST_INCR : (r < 8) ? BURST_FIXED : (r == 8) ? BURST_WRAP : 2'b11;
            if ($urandom_range(0, 1) == 1) begin
                wq_data.delete(); wq_strb.delete();
                for (int i = 0; i <= int'(len); i++) begin
                    wq_data.push_back($urandom); wq_strb.push_back(4'($urandom));
                end
                model_write(addr, len, burst, eresp);
                axi_write(id, addr, len, burst, int'($urandom_range(0, 2)), bresp, bid);
                check($sformatf("rand%0d bresp", t), bresp, eresp);
                check($sformatf("rand%0d bid", t), bid, id);
            end else begin
                model_read(addr, len, burst);
                axi_read(id, addr, len, burst, $urandom_range(0, 1) == 1);
                compare_read($sformatf("rand%0d", t), len, id);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
